// File: rtl/vga_func_pkg.sv
// Shared definitions for the display-function switch sequencer.
// Holds the FSM state encoding, the pending-request encoding, the function
// index constants and the default function count.
// Optional feature macro used by the sequencer: FUNC_SWITCH_REVERSE_EN.
package vga_func_pkg;

  localparam int unsigned NUM_FUNC_DEFAULT = 3;
  localparam int unsigned HOLD_W           = 4;

  // Function indices shared by the ROM/RGB muxes.
  localparam int unsigned FUNC_COLOR = 0;
  localparam int unsigned FUNC_PIC   = 1;
  localparam int unsigned FUNC_GAME  = 2;

  typedef enum logic [1:0] {
    ST_ACTIVE     = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_HOLD       = 2'd2,
    ST_RELEASE    = 2'd3
  } state_e;

  // Direction of a request queued while a switch is in flight.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_FWD  = 2'd1,
    PEND_BACK = 2'd2
  } pend_e;

endpackage

// File: rtl/func_idx_decode.sv
// Combinational decode of a function index.
// Ports:
//   idx_i     in   function index
//   onehot_o  out  one-hot select for idx_i
//   rst_o     out  per-function reset, inverse of onehot_o
//   thermo_o  out  thermometer code, thermo_o[k]=1 for k<=idx_i
module func_idx_decode #(
  parameter int unsigned NUM_FUNC = 3
) (
  input  logic [$clog2(NUM_FUNC)-1:0] idx_i,
  output logic [NUM_FUNC-1:0]         onehot_o,
  output logic [NUM_FUNC-1:0]         rst_o,
  output logic [NUM_FUNC-1:0]         thermo_o
);

  localparam int unsigned IDX_W = $clog2(NUM_FUNC);

  // Compare against each index so out-of-range codes never select a bit.
  always_comb begin
    onehot_o = '0;
    thermo_o = '0;
    for (int unsigned k = 0; k < NUM_FUNC; k++) begin
      onehot_o[k] = (idx_i == IDX_W'(k));
      thermo_o[k] = (IDX_W'(k) <= idx_i);
    end
    rst_o = ~onehot_o;
  end

endmodule

// File: rtl/func_switch_sequencer.sv
// Sequences frame-aligned handover between display functions sharing the
// picture ROM and RGB mux. A switch blanks the screen and holds all
// functions in reset for FRAME_HOLD+1 frames, then releases the new
// function for one frame before unblanking.
// Ports:
//   vgaclk          in   pixel clock
//   reset           in   synchronous active-high reset
//   change_req      in   pulse: advance to next function
//   change_prev_req in   pulse: go to previous function (FUNC_SWITCH_REVERSE_EN only)
//   frame_start     in   pulse at first cycle of vertical blanking
//   func_sel        out  one-hot active function
//   func_rst        out  per-function reset
//   blank           out  force RGB black
//   led             out  thermometer of active index
//   busy            out  switch in progress
// Optional feature macro: FUNC_SWITCH_REVERSE_EN.
module func_switch_sequencer
  import vga_func_pkg::*;
#(
  parameter int unsigned NUM_FUNC   = NUM_FUNC_DEFAULT,
  parameter int unsigned FRAME_HOLD = 2
) (
  input  logic                vgaclk,
  input  logic                reset,
  input  logic                change_req,
`ifdef FUNC_SWITCH_REVERSE_EN
  input  logic                change_prev_req,
`endif
  input  logic                frame_start,
  output logic [NUM_FUNC-1:0] func_sel,
  output logic [NUM_FUNC-1:0] func_rst,
  output logic                blank,
  output logic [NUM_FUNC-1:0] led,
  output logic                busy
);

  localparam int unsigned IDX_W = $clog2(NUM_FUNC);

  state_e             state_q, state_d;
  pend_e              pend_q, pend_d;
  logic [IDX_W-1:0]   cur_q, cur_d;
  logic [IDX_W-1:0]   next_q, next_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic [NUM_FUNC-1:0] func_sel_q, func_rst_q, led_q;
  logic                blank_q, busy_q;

  logic [NUM_FUNC-1:0] onehot_c, rst_c, thermo_c;
  logic [IDX_W-1:0]    succ_c, pred_c;
  logic                req_fwd_c, req_back_c;

  // Simultaneous forward and reverse requests cancel each other.
  always_comb begin
`ifdef FUNC_SWITCH_REVERSE_EN
    req_fwd_c  = change_req & ~change_prev_req;
    req_back_c = change_prev_req & ~change_req;
`else
    req_fwd_c  = change_req;
    req_back_c = 1'b0;
`endif
  end

  // Wrapping neighbours of the current index.
  always_comb begin
    succ_c = (cur_q == IDX_W'(NUM_FUNC - 1)) ? '0 : cur_q + IDX_W'(1);
    pred_c = (cur_q == '0) ? IDX_W'(NUM_FUNC - 1) : cur_q - IDX_W'(1);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cur_d   = cur_q;
    next_d  = next_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_ACTIVE: begin
        // A queued request restarts a switch immediately; a frame_start
        // in this cycle is never consumed.
        if (pend_q != PEND_NONE) begin
          next_d  = (pend_q == PEND_BACK) ? pred_c : succ_c;
          pend_d  = PEND_NONE;
          state_d = ST_WAIT_FRAME;
        end else if (req_fwd_c) begin
          next_d  = succ_c;
          state_d = ST_WAIT_FRAME;
        end else if (req_back_c) begin
          next_d  = pred_c;
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          hold_d  = HOLD_W'(FRAME_HOLD);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (frame_start) begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else begin
            cur_d   = next_q;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (frame_start) state_d = ST_ACTIVE;
      end
      default: state_d = ST_ACTIVE;
    endcase

    // Only the first request during a switch is remembered.
    if (state_q != ST_ACTIVE && pend_q == PEND_NONE) begin
      if (req_fwd_c)       pend_d = PEND_FWD;
      else if (req_back_c) pend_d = PEND_BACK;
    end
  end

  // Decode the upcoming index so the outputs can be registered.
  func_idx_decode #(.NUM_FUNC(NUM_FUNC)) u_idx_decode (
    .idx_i    (cur_d),
    .onehot_o (onehot_c),
    .rst_o    (rst_c),
    .thermo_o (thermo_c)
  );

  // State and output registers.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_q    <= ST_ACTIVE;
      pend_q     <= PEND_NONE;
      cur_q      <= '0;
      next_q     <= '0;
      hold_q     <= '0;
      func_sel_q <= NUM_FUNC'(1);
      func_rst_q <= ~NUM_FUNC'(1);
      led_q      <= NUM_FUNC'(1);
      blank_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      next_q     <= next_d;
      hold_q     <= hold_d;
      func_sel_q <= onehot_c;
      led_q      <= thermo_c;
      // Everything stays in reset from the request until release.
      func_rst_q <= (state_d == ST_WAIT_FRAME || state_d == ST_HOLD) ? '1 : rst_c;
      blank_q    <= (state_d == ST_HOLD || state_d == ST_RELEASE);
      busy_q     <= (state_d != ST_ACTIVE);
    end
  end

  assign func_sel = func_sel_q;
  assign func_rst = func_rst_q;
  assign led      = led_q;
  assign blank    = blank_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_func_switch_sequencer.sv
// Directed bench for func_switch_sequencer (NUM_FUNC=3, FRAME_HOLD=2).
module tb_func_switch_sequencer;

  logic       vgaclk = 1'b0;
  logic       reset = 1'b1;
  logic       change_req = 1'b0;
  logic       frame_start = 1'b0;
  logic [2:0] func_sel, func_rst, led;
  logic       blank, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  func_switch_sequencer #(.NUM_FUNC(3), .FRAME_HOLD(2)) dut (
    .vgaclk      (vgaclk),
    .reset       (reset),
    .change_req  (change_req),
    .frame_start (frame_start),
    .func_sel    (func_sel),
    .func_rst    (func_rst),
    .blank       (blank),
    .led         (led),
    .busy        (busy)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] sel, input logic [2:0] rst,
                         input logic blk, input logic [2:0] ld, input logic bsy);
    chk({tag, ".sel"},   32'(func_sel), 32'(sel));
    chk({tag, ".rst"},   32'(func_rst), 32'(rst));
    chk({tag, ".blank"}, 32'(blank),    32'(blk));
    chk({tag, ".led"},   32'(led),      32'(ld));
    chk({tag, ".busy"},  32'(busy),     32'(bsy));
  endtask

  // Inputs change on the falling edge; outputs are read on the next one.
  task automatic pulse(input logic fs, input logic cr, input logic rs);
    frame_start = fs;
    change_req  = cr;
    reset       = rs;
    @(negedge vgaclk);
    frame_start = 1'b0;
    change_req  = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge vgaclk);
  endtask

  task automatic frame();
    idle(8);
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  // Full forward switch: request then five frames back to ACTIVE.
  task automatic do_switch();
    idle(3);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (5) frame();
  endtask

  initial begin
    @(negedge vgaclk);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk_out("reset", 3'b001, 3'b110, 1'b0, 3'b001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      frame();
      chk_out("idle_frame", 3'b001, 3'b110, 1'b0, 3'b001, 1'b0);
    end

    // Basic switch 0 -> 1.
    idle(10);
    pulse(1'b0, 1'b1, 1'b0);
    chk("req.busy", 32'(busy), 32'd1);
    chk("req.blank", 32'(blank), 32'd0);
    chk("req.sel", 32'(func_sel), 32'h1);
    frame();
    chk_out("fs1", 3'b001, 3'b111, 1'b1, 3'b001, 1'b1);
    frame();
    chk_out("fs2", 3'b001, 3'b111, 1'b1, 3'b001, 1'b1);
    frame();
    chk_out("fs3", 3'b001, 3'b111, 1'b1, 3'b001, 1'b1);
    frame();
    chk_out("fs4", 3'b010, 3'b101, 1'b1, 3'b011, 1'b1);
    frame();
    chk_out("fs5", 3'b010, 3'b101, 1'b0, 3'b011, 1'b0);

    // 1 -> 2, then wrap 2 -> 0.
    do_switch();
    chk_out("to2", 3'b100, 3'b011, 1'b0, 3'b111, 1'b0);
    do_switch();
    chk_out("wrap", 3'b001, 3'b110, 1'b0, 3'b001, 1'b0);

    // Request coincident with frame_start: that frame is not consumed.
    idle(3);
    pulse(1'b1, 1'b1, 1'b0);
    chk("coinc.busy", 32'(busy), 32'd1);
    chk("coinc.blank", 32'(blank), 32'd0);
    frame();
    chk("coinc.next_blank", 32'(blank), 32'd1);
    repeat (4) frame();
    chk_out("coinc.done", 3'b010, 3'b101, 1'b0, 3'b011, 1'b0);

    // Back to 0 via 2.
    do_switch();
    do_switch();
    chk_out("back0", 3'b001, 3'b110, 1'b0, 3'b001, 1'b0);

    // Two requests during HOLD: one queued, one dropped.
    idle(3);
    pulse(1'b0, 1'b1, 1'b0);
    frame();
    idle(2);
    pulse(1'b0, 1'b1, 1'b0);
    idle(2);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (3) frame();
    chk_out("pend.rel1", 3'b010, 3'b101, 1'b1, 3'b011, 1'b1);
    frame();
    chk_out("pend.act1", 3'b010, 3'b101, 1'b0, 3'b011, 1'b0);
    idle(1);
    chk("pend.restart", 32'(busy), 32'd1);
    repeat (5) frame();
    chk_out("pend.final", 3'b100, 3'b011, 1'b0, 3'b111, 1'b0);
    frame();
    chk_out("pend.dropped", 3'b100, 3'b011, 1'b0, 3'b111, 1'b0);

    // Reset in HOLD with a queued request.
    idle(3);
    pulse(1'b0, 1'b1, 1'b0);
    frame();
    chk("hold.blank", 32'(blank), 32'd1);
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk_out("rst_hold", 3'b001, 3'b110, 1'b0, 3'b001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      frame();
      chk_out("rst_after", 3'b001, 3'b110, 1'b0, 3'b001, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
